// File: rtl/vliw_scoreboard_if.sv
// Issue-stage bundle interface between decode and the VLIW register scoreboard.
// master = decode side driving a bundle, slave = scoreboard answering with stall/fire status.
interface vliw_scoreboard_if #(
  parameter int NUM_SLOTS = 2,
  parameter int REG_AW    = 3,
  parameter int LAT_W     = 3,
  parameter int CNT_W     = 16
);
  logic [NUM_SLOTS-1:0]        issue_valid;
  logic [NUM_SLOTS*REG_AW-1:0] src_a;
  logic [NUM_SLOTS*REG_AW-1:0] src_b;
  logic [NUM_SLOTS*2-1:0]      src_re;
  logic [NUM_SLOTS*REG_AW-1:0] dst;
  logic [NUM_SLOTS-1:0]        dst_we;
  logic [NUM_SLOTS*LAT_W-1:0]  dst_lat;
  logic                        flush;
  logic                        stall;
  logic                        issue_fire;
  logic [2**REG_AW-1:0]        busy;
  logic                        err_dual_wr;
  logic [CNT_W-1:0]            stall_cnt;

  modport master (
    output issue_valid, src_a, src_b, src_re, dst, dst_we, dst_lat, flush,
    input  stall, issue_fire, busy, err_dual_wr, stall_cnt
  );

  modport slave (
    input  issue_valid, src_a, src_b, src_re, dst, dst_we, dst_lat, flush,
    output stall, issue_fire, busy, err_dual_wr, stall_cnt
  );
endinterface

// File: rtl/vliw_scoreboard.sv
// N-slot VLIW register scoreboard: per-register latency countdown, RAW/WAW bundle stall,
// sticky same-bundle dual-write flag. Define SCOREBOARD_BYPASS_EN to treat cnt==1 sources as ready.
module vliw_scoreboard #(
  parameter int NUM_SLOTS = 2,
  parameter int REG_AW    = 3,
  parameter int LAT_W     = 3,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  vliw_scoreboard_if.slave  sb
);
  localparam int NUM_REGS = 2**REG_AW;

`ifdef SCOREBOARD_BYPASS_EN
  // Result is forwarded the cycle after cnt reaches 1, so that source is already usable.
  localparam logic [LAT_W-1:0] THR = LAT_W'(1);
`else
  localparam logic [LAT_W-1:0] THR = '0;
`endif

  logic [LAT_W-1:0]     cnt_q [NUM_REGS];
  logic [LAT_W-1:0]     cnt_d [NUM_REGS];
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
  logic                 err_q, err_d;

  logic [LAT_W-1:0]     eff_lat [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] wr_en;
  logic [NUM_SLOTS-1:0] raw, waw;
  logic                 dup_wr;
  logic                 stall, fire;
  logic [NUM_REGS-1:0]  busy;

  assign wr_en = sb.issue_valid & sb.dst_we;

  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      eff_lat[s] = (sb.dst_lat[s*LAT_W +: LAT_W] == '0) ? LAT_W'(1)
                                                         : sb.dst_lat[s*LAT_W +: LAT_W];
    end
  end

  // All hazard checks look at pre-bundle counters, so intra-bundle forwarding is never a hazard.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
    raw    = '0;
    waw    = '0;
    dup_wr = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      raw[s] = sb.issue_valid[s] &
               ((sb.src_re[2*s]   & (cnt_q[sb.src_a[s*REG_AW +: REG_AW]] > THR)) |
                (sb.src_re[2*s+1] & (cnt_q[sb.src_b[s*REG_AW +: REG_AW]] > THR)));
      waw[s] = wr_en[s] & (cnt_q[sb.dst[s*REG_AW +: REG_AW]] > eff_lat[s]);
      for (int t = 0; t < s; t++) begin
        if (wr_en[s] && wr_en[t] &&
            (sb.dst[s*REG_AW +: REG_AW] == sb.dst[t*REG_AW +: REG_AW])) begin
          dup_wr = 1'b1;
        end
      end
    end
  end

  assign stall = |(raw | waw);
  assign fire  = (|sb.issue_valid) & ~stall & ~sb.flush;

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
    end
    // Ascending slot order lets the highest writing slot win a shared destination.
    if (fire) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (wr_en[s]) cnt_d[sb.dst[s*REG_AW +: REG_AW]] = eff_lat[s];
      end
    end
  end

  assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
  assign err_d       = err_q | (fire & dup_wr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the counter array is architectural state that must read as idle after reset,
      // so unlike a data RAM every entry is cleared here.
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the same pre-edge values.
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NUM_REGS; r++) busy[r] = |cnt_q[r];
  end

  assign sb.stall       = stall;
  assign sb.issue_fire  = fire;
  assign sb.busy        = busy;
  assign sb.err_dual_wr = err_q;
  assign sb.stall_cnt   = stall_cnt_q;
endmodule

// File: tb/tb_vliw_scoreboard.sv
// Self-checking bench for vliw_scoreboard: a write-back-time model checked every cycle,
// directed scenarios with literal expectations, then randomized bundles.
module tb_vliw_scoreboard;
  localparam int NS = 2;
  localparam int AW = 3;
  localparam int LW = 3;
  localparam int CW = 16;
  localparam int NR = 2**AW;
`ifdef SCOREBOARD_BYPASS_EN
  localparam int THR     = 1;
  localparam int RAW_LIT = 1;
`else
  localparam int THR     = 0;
  localparam int RAW_LIT = 2;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vliw_scoreboard_if #(.NUM_SLOTS(NS), .REG_AW(AW), .LAT_W(LW), .CNT_W(CW)) bus ();
  vliw_scoreboard #(.NUM_SLOTS(NS), .REG_AW(AW), .LAT_W(LW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: absolute cycle at which each register's pending write completes.
  int cyc = 0;
  int wb[NR];
  bit err_m;
  int scnt_m;
  bit last_stall, last_fire;

  bit v[NS], ae[NS], be[NS], we[NS];
  int sa[NS], sbr[NS], ds[NS], lt[NS];
  bit fl;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rem(input int r);
    return (wb[r] > cyc) ? wb[r] - cyc : 0;
  endfunction

  function automatic int eff(input int l);
    return (l == 0) ? 1 : l;
  endfunction

  task automatic clear();
    for (int s = 0; s < NS; s++) begin
      v[s] = 0; ae[s] = 0; be[s] = 0; we[s] = 0;
      sa[s] = 0; sbr[s] = 0; ds[s] = 0; lt[s] = 0;
    end
    fl = 0;
  endtask

  task automatic apply();
    for (int s = 0; s < NS; s++) begin
      bus.issue_valid[s]         = v[s];
      bus.src_re[2*s]            = ae[s];
      bus.src_re[2*s+1]          = be[s];
      bus.dst_we[s]              = we[s];
      bus.src_a[s*AW +: AW]      = AW'(sa[s]);
      bus.src_b[s*AW +: AW]      = AW'(sbr[s]);
      bus.dst[s*AW +: AW]        = AW'(ds[s]);
      bus.dst_lat[s*LW +: LW]    = LW'(lt[s]);
    end
    bus.flush = fl;
  endtask

  function automatic void model_reset();
    for (int r = 0; r < NR; r++) wb[r] = 0;
    err_m  = 0;
    scnt_m = 0;
  endfunction

  // One clock: drive at negedge, compare mid-cycle, advance model at posedge.
  task automatic step();
    bit es, ef, dup, anyv;
    logic [NR-1:0] eb;
    apply();
    #1;
    es = 0; dup = 0; anyv = 0;
    for (int s = 0; s < NS; s++) begin
      if (v[s]) begin
        anyv = 1;
        if (ae[s] && rem(sa[s])  > THR) es = 1;
        if (be[s] && rem(sbr[s]) > THR) es = 1;
        if (we[s] && rem(ds[s]) > eff(lt[s])) es = 1;
      end
      for (int t = 0; t < s; t++)
        if (v[s] && we[s] && v[t] && we[t] && ds[s] == ds[t]) dup = 1;
    end
    ef = anyv && !es && !fl;
    for (int r = 0; r < NR; r++) eb[r] = (rem(r) != 0);
    check("stall", bus.stall, es);
    check("issue_fire", bus.issue_fire, ef);
    check("busy", bus.busy, eb);
    check("err_dual_wr", bus.err_dual_wr, err_m);
    check("stall_cnt", bus.stall_cnt, scnt_m);
    last_stall = es;
    last_fire  = ef;
    @(posedge clk);
    if (ef)
      for (int s = 0; s < NS; s++)
        if (v[s] && we[s]) wb[ds[s]] = cyc + 1 + eff(lt[s]);
    if (ef && dup) err_m = 1;
    if (es && scnt_m < (2**CW - 1)) scnt_m++;
    cyc++;
    @(negedge clk);
  endtask

  int n, s0;

  initial begin
    reset = 1'b0;
    model_reset();
    clear();
    apply();
    #1;
    check("rst_stall", bus.stall, 0);
    check("rst_fire", bus.issue_fire, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err_dual_wr, 0);
    check("rst_stall_cnt", bus.stall_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Single write r3 lat 3 and its countdown.
    clear(); v[0] = 1; we[0] = 1; ds[0] = 3; lt[0] = 3;
    step();
    clear();
    check("t1_busy3_set", bus.busy[3], 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_busy3_count", bus.busy[3], (i < 2) ? 1 : 0);
    end

    // RAW: write r3 lat 3, idle cycle, slot1 reads r3.
    clear(); v[0] = 1; we[0] = 1; ds[0] = 3; lt[0] = 3;
    step();
    clear();
    step();
    v[1] = 1; ae[1] = 1; sa[1] = 3;
    s0 = scnt_m; n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (last_fire) break;
      if (last_stall) n++;
    end
    check("raw_fired", last_fire, 1);
    check("raw_stall_cycles", n, RAW_LIT);
    check("raw_stall_cnt", int'(bus.stall_cnt) - s0, RAW_LIT);
    clear();
    repeat (4) step();

    // WAW: r5 pending cnt 3, new write r5 lat 1 waits until cnt<=1.
    clear(); v[0] = 1; we[0] = 1; ds[0] = 5; lt[0] = 3;
    step();
    lt[0] = 1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (last_fire) break;
      if (last_stall) n++;
    end
    check("waw_stall_cycles", n, 2);
    clear();
    check("waw_busy5_reload", bus.busy[5], 1);
    step();
    check("waw_busy5_done", bus.busy[5], 0);

    // Same-bundle dual write to r2: slot1 (lat 4) wins, error becomes sticky.
    clear();
    v[0] = 1; we[0] = 1; ds[0] = 2; lt[0] = 2;
    v[1] = 1; we[1] = 1; ds[1] = 2; lt[1] = 4;
    step();
    clear();
    check("dual_err_set", bus.err_dual_wr, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("dual_busy2", bus.busy[2], (i < 3) ? 1 : 0);
    end
    check("dual_err_sticky", bus.err_dual_wr, 1);

    // Flush of a hazard-free bundle, then release.
    clear(); v[0] = 1; we[0] = 1; ds[0] = 6; lt[0] = 2; fl = 1;
    step();
    check("flush_busy6", bus.busy[6], 0);
    fl = 0;
    step();
    check("flush_release_fire", last_fire, 1);
    check("flush_busy6_after", bus.busy[6], 1);
    clear();
    repeat (3) step();

    // Async reset mid-countdown.
    clear(); v[0] = 1; we[0] = 1; ds[0] = 1; lt[0] = 3;
    step();
    clear(); apply();
    #2;
    reset = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_stall_cnt", bus.stall_cnt, 0);
    check("arst_err", bus.err_dual_wr, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    clear(); v[1] = 1; ae[1] = 1; sa[1] = 1; be[1] = 1; sbr[1] = 1;
    apply();
    #1;
    check("post_rst_stall", bus.stall, 0);
    check("post_rst_fire", bus.issue_fire, 1);
    @(negedge clk);
    step();
    clear();

    // Randomized bundles checked against the model every cycle.
    for (int i = 0; i < 500; i++) begin
      for (int s = 0; s < NS; s++) begin
        v[s]   = ($urandom_range(3) != 0);
        ae[s]  = $urandom_range(1);
        be[s]  = $urandom_range(1);
        we[s]  = v[s] & ($urandom_range(1) == 1);
        sa[s]  = $urandom_range(NR - 1);
        sbr[s] = $urandom_range(NR - 1);
        ds[s]  = $urandom_range(NR - 1);
        lt[s]  = $urandom_range(2**LW - 1);
      end
      fl = ($urandom_range(9) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
